grid_renderer: RTL and testbench
================================

Name: grid_renderer

Overview:
- Downstream consumer of the map grid storage. On a start pulse it scans every cell of the GRID_W x GRID_H map through the grid's read port.
- Maps each 3-bit tile code to a 3-bit colour and paints a CELL_PX x CELL_PX pixel square per cell into the VGA adapter's plot interface.
- It owns the grid read port (readwrite held 0) while busy; game logic must not write the grid while busy=1.

Parameters:
- GRID_W, 20, cells per row.
- GRID_H, 20, cells per column.
- CELL_PX, 5, pixel edge length of one cell.
- READ_LAT, 2, grid read latency in clocks from coordinate change to valid data_out.

Ports:
- clock_50  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-high reset (1 = reset).
- start  in  1  one-cycle request to render a full frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse when the frame is complete.
- grid_x  out  5  cell column to grid read port.
- grid_y  out  5  cell row to grid read port.
- grid_rw  out  1  constant 0 (read) to grid readwrite.
- grid_data  in  3  tile code returned by grid.
- vga_x  out  8  pixel x = grid_x*CELL_PX + px.
- vga_y  out  7  pixel y = grid_y*CELL_PX + py.
- colour  out  3  pixel colour.
- plot  out  1  write-enable to VGA adapter, one pixel per cycle.

Behaviour:
- Reset (async, reset_n=1): state IDLE; busy, done, plot, colour, vga_x, vga_y, grid_x, grid_y all 0; internal counters 0. Reset mid-frame aborts immediately, with no done pulse.
- States: IDLE, ADDR, WAIT, PAINT, DONE.
- IDLE: start=1 moves to ADDR; grid_x=grid_y=0.
- ADDR: one cycle; the coordinate is stable on grid_x/grid_y; goes to WAIT.
- WAIT: READ_LAT cycles. On the last cycle, grid_data is captured into tile_reg and the colour is precomputed; goes to PAINT.
- PAINT: CELL_PX*CELL_PX cycles with plot=1 in every one.
  - px runs 0..CELL_PX-1 fastest, then py.
  - vga_x/vga_y/colour are registered and valid in the same cycle as plot.
- After the last pixel:
  - If grid_x < GRID_W-1: increment grid_x and go to ADDR.
  - Else, if grid_y < GRID_H-1: set grid_x=0, increment grid_y, go to ADDR.
  - Else: go to DONE.
- DONE: one cycle with done=1, busy=1, plot=0; then IDLE with busy=0.
- Per-cell cost: 1 + READ_LAT + CELL_PX² cycles. Default: 28 cycles/cell, 11200 cycles/frame, then DONE.
- start while busy is ignored, not queued.
- grid_x/grid_y change only on ADDR entry, so they are stable through WAIT and PAINT.
- Colour map (tile -> colour):
  - 0 empty -> 000 black
  - 1 wall -> 001 blue
  - 2 pellet -> 111 white
  - 3 power pellet -> 110 yellow-white
  - 4 pacman -> 110 yellow
  - 5 ghost -> 100 red
  - 6, 7 undefined -> 101 magenta (debug marker)
- Width rules:
  - vga_x = grid_x*CELL_PX + px, computed at 8 bits.
  - vga_y = grid_y*CELL_PX + py, computed at 7 bits.
  - Defaults give at most 99 on each axis; parameters must keep GRID_W*CELL_PX ≤ 160 and GRID_H*CELL_PX ≤ 120. This is checked at elaboration.

Optional Feature:
- Macro: GRID_RENDER_PELLET_DOT_EN.
- Defined: tiles 2 and 3 paint their colour only at the centre pixel (px=py=CELL_PX/2). Tile 3 additionally paints the 4-neighbours of the centre. All other pixels of those cells are 000. Plot is still asserted for all CELL_PX² pixels, so timing is unchanged.
- Undefined: every tile fills its whole square with the mapped colour.

Test Plan:
- Reset: assert reset_n=1 mid-PAINT -> same cycle busy=0, plot=0, done=0, grid_x=grid_y=0; release and start -> frame restarts at cell (0,0).
- All-empty grid model (READ_LAT=2), start at edge E0:
  - exactly 10000 plot cycles, all colour=000;
  - done=1 only in cycle E0+11201;
  - busy high cycles E0+1..E0+11201.
- Single wall at (19,19), rest empty -> colour=001 exactly on vga_x 95..99, vga_y 95..99 (25 plots), 000 elsewhere.
- Tile 7 at (3,0) -> 25 plots colour=101 at vga_x 15..19, vga_y 0..4.
- start pulsed again at cycles E0+5 and E0+11200 -> ignored, single done. start in the cycle after done -> new frame accepted.
- With GRID_RENDER_PELLET_DOT_EN, pellet at (0,0) -> colour=111 only at (2,2), 25 plots. Without the macro -> 25 plots of 111.

Source files
------------

// File: rtl/grid_renderer.sv
// grid_renderer: scans the map grid and paints one CELL_PX square per cell.
// Build option GRID_RENDER_PELLET_DOT_EN: pellet tiles drawn as dot / plus.
module grid_renderer #(
  parameter int GRID_W   = 20,
  parameter int GRID_H   = 20,
  parameter int CELL_PX  = 5,
  parameter int READ_LAT = 2
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] grid_x,
  output logic [4:0] grid_y,
  output logic       grid_rw,
  input  logic [2:0] grid_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [PW-1:0] PX_LAST = PW'(CELL_PX - 1);
  localparam logic [WW-1:0] W_LAST  = WW'(READ_LAT - 1);
  localparam logic [4:0]    GX_LAST = 5'(GRID_W - 1);
  localparam logic [4:0]    GY_LAST = 5'(GRID_H - 1);

  if (GRID_W * CELL_PX > 160 || GRID_H * CELL_PX > 120 ||
      GRID_W > 32 || GRID_H > 32 || READ_LAT < 1 || CELL_PX < 1)
  begin : g_bad_params
    $error("grid_renderer: parameters exceed VGA or port range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_PAINT, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [4:0]    gx_q, gx_d, gy_q, gy_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [PW-1:0] nx, ny;
  logic [2:0]    tile_q, tile_d, tile_sel;
  logic [7:0]    vx_q, vx_d;
  logic [6:0]    vy_q, vy_d;
  logic [2:0]    col_q, col_d;
  logic          wait_last, pix_last, cell_last, load;

  function automatic logic [2:0] map_colour(input logic [2:0] t);
    logic [2:0] c;
    unique case (t)
      3'd0:    c = 3'b000;
      3'd1:    c = 3'b001;
      3'd2:    c = 3'b111;
      3'd3:    c = 3'b110;
      3'd4:    c = 3'b110;
      3'd5:    c = 3'b100;
      default: c = 3'b101;
    endcase
    return c;
  endfunction

`ifdef GRID_RENDER_PELLET_DOT_EN
  // Manhattan distance from the cell centre selects dot (2) or plus (3).
  function automatic logic [2:0] dot_colour(
    input logic [2:0] t,
    input logic [PW-1:0] x,
    input logic [PW-1:0] y
  );
    int dx, dy;
    logic [2:0] c;
    c  = map_colour(t);
    dx = int'(x) - CELL_PX / 2;
    dy = int'(y) - CELL_PX / 2;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    if (t == 3'd2 && (dx + dy) != 0) c = 3'b000;
    if (t == 3'd3 && (dx + dy) > 1)  c = 3'b000;
    return c;
  endfunction
`endif

  assign wait_last = (wcnt_q == W_LAST);
  assign pix_last  = (px_q == PX_LAST) && (py_q == PX_LAST);
  assign cell_last = (gx_q == GX_LAST) && (gy_q == GY_LAST);
  assign tile_sel  = (state_q == S_WAIT) ? grid_data : tile_q;

  always_ff @(posedge clock_50 or posedge reset_n) begin
    if (reset_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  if (wait_last) state_d = S_PAINT;
      S_PAINT: if (pix_last) state_d = cell_last ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    plot = (state_q == S_PAINT);
  end

  always_comb begin
    nx = '0;
    ny = '0;
    if (state_q == S_PAINT) begin
      if (px_q == PX_LAST) begin
        ny = py_q + PW'(1);
      end else begin
        nx = px_q + PW'(1);
        ny = py_q;
      end
    end
  end

  always_comb begin
    gx_d   = gx_q;
    gy_d   = gy_q;
    wcnt_d = wcnt_q;
    px_d   = px_q;
    py_d   = py_q;
    tile_d = tile_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    col_d  = col_q;
    load   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gx_d = '0;
        gy_d = '0;
      end
      S_ADDR: wcnt_d = '0;
      S_WAIT: begin
        wcnt_d = wcnt_q + WW'(1);
        if (wait_last) begin
          tile_d = grid_data;
          load   = 1'b1;
        end
      end
      S_PAINT: begin
        if (!pix_last) begin
          load = 1'b1;
        end else if (gx_q != GX_LAST) begin
          gx_d = gx_q + 5'd1;
        end else if (gy_q != GY_LAST) begin
          gx_d = '0;
          gy_d = gy_q + 5'd1;
        end
      end
      S_DONE: begin
        gx_d = '0;
        gy_d = '0;
      end
      default: ;
    endcase
    if (load) begin
      px_d = nx;
      py_d = ny;
      vx_d = 8'(gx_q) * 8'(CELL_PX) + 8'(nx);
      vy_d = 7'(gy_q) * 7'(CELL_PX) + 7'(ny);
`ifdef GRID_RENDER_PELLET_DOT_EN
      col_d = dot_colour(tile_sel, nx, ny);
`else
      col_d = map_colour(tile_sel);
`endif
    end
  end

  always_ff @(posedge clock_50 or posedge reset_n) begin
    if (reset_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      wcnt_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
      tile_q <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
      col_q  <= '0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      wcnt_q <= wcnt_d;
      px_q   <= px_d;
      py_q   <= py_d;
      tile_q <= tile_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      col_q  <= col_d;
    end
  end

  assign grid_x  = gx_q;
  assign grid_y  = gy_q;
  assign grid_rw = 1'b0;
  assign vga_x   = vx_q;
  assign vga_y   = vy_q;
  assign colour  = col_q;

endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: random/directed frames checked against a cycle-index model.
// Model derives every output from the frame cycle number and the tile map.
module tb_grid_renderer;

  localparam int GW = 20, GH = 20, CP = 5, RL = 2;
  localparam int CYC    = 1 + RL + CP * CP;
  localparam int FRAME  = GW * GH * CYC;
  localparam int DONE_N = FRAME + 1;
`ifdef GRID_RENDER_PELLET_DOT_EN
  localparam bit DOT = 1'b1;
`else
  localparam bit DOT = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       busy, done, grw, plot;
  logic [4:0] gx, gy;
  logic [2:0] gdata, colour;
  logic [7:0] vx;
  logic [6:0] vy;

  always #5 clk = ~clk;

  grid_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_PX(CP), .READ_LAT(RL)
  ) dut (
    .clock_50(clk), .reset_n(rst), .start(start),
    .busy(busy), .done(done),
    .grid_x(gx), .grid_y(gy), .grid_rw(grw),
    .grid_data(gdata),
    .vga_x(vx), .vga_y(vy), .colour(colour), .plot(plot)
  );

  // grid storage with RL-cycle read latency
  logic [2:0] mem [GW][GH];
  logic [2:0] s [RL];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) s[i] <= s[i-1];
    s[0] <= (gx < GW && gy < GH) ? mem[gx][gy] : 3'd0;
  end
  assign gdata = s[RL-1];

  // n = cycle index within current frame (0 = idle)
  int n = 0;
  always @(posedge clk or posedge rst) begin
    if (rst)              n = 0;
    else if (n == 0)      n = start ? 1 : 0;
    else if (n == DONE_N) n = 0;
    else                  n = n + 1;
  end

  int checks = 0, errs = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)",
               nm, act, exp, n, $time);
    end
  endtask

  function automatic logic [2:0] want_colour(int t, int px, int py);
    logic [2:0] c;
    int d;
    case (t)
      0: c = 3'b000;
      1: c = 3'b001;
      2: c = 3'b111;
      3: c = 3'b110;
      4: c = 3'b110;
      5: c = 3'b100;
      default: c = 3'b101;
    endcase
    d = (px > CP/2 ? px - CP/2 : CP/2 - px) +
        (py > CP/2 ? py - CP/2 : CP/2 - py);
    if (DOT && t == 2 && d != 0) c = 3'b000;
    if (DOT && t == 3 && d > 1)  c = 3'b000;
    return c;
  endfunction

  // DUT observations per frame
  logic [2:0] img [160][120];
  int plot_cnt, nz_cnt, done_cnt, done_at, busy_cnt;

  task automatic clear_stats();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) img[x][y] = 3'd0;
    plot_cnt = 0; nz_cnt = 0; done_cnt = 0;
    done_at = -1; busy_cnt = 0;
  endtask

  function automatic int count_col(logic [2:0] c);
    int k = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        if (img[x][y] == c) k++;
    return k;
  endfunction

  always @(negedge clk) begin
    int k, r, cx, cy, p, px, py;
    bit eplot, gchk;
    eplot = 1'b0;
    gchk  = 1'b1;
    cx = 0; cy = 0; px = 0; py = 0;
    if (n >= 1 && n <= FRAME) begin
      k  = (n - 1) / CYC;
      r  = (n - 1) % CYC;
      cx = k % GW;
      cy = k / GW;
      if (r >= 1 + RL) begin
        eplot = 1'b1;
        p  = r - 1 - RL;
        px = p % CP;
        py = p / CP;
      end
    end else if (n == DONE_N) begin
      gchk = 1'b0;
    end
    chk("busy", int'(busy), int'(n >= 1));
    chk("done", int'(done), int'(n == DONE_N));
    chk("plot", int'(plot), int'(eplot));
    chk("grid_rw", int'(grw), 0);
    if (gchk)
      chk("grid_xy", int'({gx, gy}), cx * 32 + cy);
    if (eplot)
      chk("pixel", int'({vx, vy, colour}),
          (((cx * CP + px) * 128) + cy * CP + py) * 8 +
          int'(want_colour(int'(mem[cx][cy]), px, py)));
    if (plot) begin
      plot_cnt++;
      if (colour != 3'd0) nz_cnt++;
      if (vx < 160 && vy < 120) img[vx][vy] = colour;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = n;
    end
  end

  task automatic clear_mem();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) mem[x][y] = 3'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_n(input int target);
    int lim = 0;
    while (n != target && lim < FRAME + 100) begin
      @(posedge clk); #1;
      lim++;
    end
    if (n != target) chk("wait_n_timeout", n, target);
  endtask

  task automatic wait_done();
    int lim = 0;
    while (done_cnt == 0 && lim < FRAME + 100) begin
      @(posedge clk); #1;
      lim++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_frame();
    clear_stats();
    @(posedge clk); #1;
    pulse_start();
    wait_done();
  endtask

  initial begin
    clear_mem();
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_vga", int'({vx, vy, colour}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // frame A: empty map, extra starts must be ignored
    pulse_start();
    wait_n(5);
    pulse_start();
    wait_n(FRAME);
    pulse_start();
    wait_done();
    chk("A_plots", plot_cnt, 10000);
    chk("A_nonzero", nz_cnt, 0);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_done_at", done_at, 11201);
    chk("A_busy_cnt", busy_cnt, 11201);

    // frame B: start right after done, then reset mid-paint
    clear_stats();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("B_accepted", n, 1);
    wait_n(2 * CYC + 1 + RL + 7);
    chk("B_plotting", int'(plot), 1);
    rst = 1'b1;
    #1;
    chk("B_rst_busy", int'(busy), 0);
    chk("B_rst_plot", int'(plot), 0);
    chk("B_rst_done", int'(done), 0);
    chk("B_rst_grid", int'({gx, gy}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("B_no_done", done_cnt, 0);

    // frame C: single wall at (19,19)
    mem[19][19] = 3'd1;
    run_frame();
    chk("C_plots", plot_cnt, 10000);
    chk("C_blue_cnt", count_col(3'd1), 25);
    chk("C_blue_lo", int'(img[95][95]), 1);
    chk("C_blue_hi", int'(img[99][99]), 1);
    chk("C_left", int'(img[94][97]), 0);
    chk("C_below", int'(img[97][100]), 0);

    // frame D: undefined tile at (3,0), pellet at (0,0)
    clear_mem();
    mem[3][0] = 3'd7;
    mem[0][0] = 3'd2;
    run_frame();
    chk("D_mag_cnt", count_col(3'd5), 25);
    chk("D_mag_lo", int'(img[15][0]), 5);
    chk("D_mag_hi", int'(img[19][4]), 5);
    chk("D_mag_out", int'(img[20][0]), 0);
    chk("D_pel_cnt", count_col(3'd7), DOT ? 1 : 25);
    chk("D_pel_ctr", int'(img[2][2]), 7);
    chk("D_pel_corner", int'(img[0][0]), DOT ? 0 : 7);

    // frame E: random tiles, model-checked every cycle
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++)
        mem[x][y] = 3'($urandom_range(0, 7));
    run_frame();
    chk("E_plots", plot_cnt, 10000);
    chk("E_done_at", done_at, 11201);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
